// File: rtl/ibex_retire_counter.sv
// Retired-instruction counter (minstret) with compressed-retire count, wrap flags and CSR writes.
// Optional speculative read path enabled by defining IBEX_RETIRE_SPEC_READ_EN.
module ibex_retire_counter #(
  parameter int unsigned CntWidth       = 64,
  parameter bit          WritebackStage = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inhibit_i,
  input  logic        instr_ret_i,
  input  logic        instr_ret_compressed_i,
  input  logic        instr_ret_spec_i,
  input  logic        csr_we_lo_i,
  input  logic        csr_we_hi_i,
  input  logic [31:0] csr_wdata_i,
  output logic [63:0] minstret_o,
  output logic [63:0] minstret_rd_o,
  output logic [31:0] ret_compressed_cnt_o,
  output logic        overflow_o,
  output logic        overflow_sticky_o
);

  typedef enum logic {
    StIdle,
    StOvf
  } sticky_state_e;

  logic [CntWidth-1:0] counter_reg, counter_next;
  logic [31:0]         cmp_reg, cmp_next;
  logic                overflow_reg;
  sticky_state_e       sticky_reg, sticky_next;
  logic                csr_we, inc, wrap;

  // A CSR write to either half suppresses the retire of the writing instruction.
  assign csr_we = csr_we_lo_i | csr_we_hi_i;
  assign inc    = instr_ret_i & ~inhibit_i & ~csr_we;
  assign wrap   = inc & (&counter_reg);

  always_comb begin
    counter_next = counter_reg;
    if (csr_we) begin
      if (csr_we_lo_i) counter_next[31:0] = csr_wdata_i;
      if (csr_we_hi_i) counter_next[CntWidth-1:32] = csr_wdata_i[CntWidth-33:0];
    end else if (inc) begin
      counter_next = counter_reg + CntWidth'(1);
    end
  end

  assign cmp_next = cmp_reg + 32'(inc & instr_ret_compressed_i);

  always_comb begin
    sticky_next = sticky_reg;
    case (sticky_reg)
      StIdle:  if (wrap) sticky_next = StOvf;
      StOvf:   if (csr_we) sticky_next = StIdle;
      default: sticky_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_reg  <= '0;
      cmp_reg      <= '0;
      overflow_reg <= 1'b0;
      sticky_reg   <= StIdle;
    end else begin
      counter_reg  <= counter_next;
      cmp_reg      <= cmp_next;
      overflow_reg <= wrap;
      sticky_reg   <= sticky_next;
    end
  end

  assign minstret_o           = 64'(counter_reg);
  assign ret_compressed_cnt_o = cmp_reg;
  assign overflow_o           = overflow_reg;
  assign overflow_sticky_o    = (sticky_reg == StOvf);

`ifdef IBEX_RETIRE_SPEC_READ_EN
  logic                spec_inc;
  logic [CntWidth-1:0] rd_cnt;

  assign spec_inc = WritebackStage & instr_ret_spec_i & ~inhibit_i;

  // During reset the counter is treated as already cleared.
  always_comb begin
    rd_cnt = counter_reg;
    if (WritebackStage) begin
      if (rst_i) rd_cnt = CntWidth'(spec_inc);
      else       rd_cnt = counter_reg + CntWidth'(spec_inc);
    end
  end

  assign minstret_rd_o = 64'(rd_cnt);
`else
  logic unused_spec;
  assign unused_spec   = instr_ret_spec_i ^ WritebackStage;
  assign minstret_rd_o = minstret_o;
`endif

endmodule

// File: tb/tb_ibex_retire_counter.sv
// Bench for ibex_retire_counter: directed table, hand sequences and random stimulus vs. a model.
module tb_ibex_retire_counter;

  logic        clk_i = 1'b0;
  logic        rst_i, inhibit_i, instr_ret_i, instr_ret_compressed_i, instr_ret_spec_i;
  logic        csr_we_lo_i, csr_we_hi_i;
  logic [31:0] csr_wdata_i;
  logic [63:0] minstret_o, minstret_rd_o;
  logic [31:0] ret_compressed_cnt_o;
  logic        overflow_o, overflow_sticky_o;

`ifdef IBEX_RETIRE_SPEC_READ_EN
  localparam bit SpecRd = 1'b1;
`else
  localparam bit SpecRd = 1'b0;
`endif

  ibex_retire_counter #(.CntWidth(64), .WritebackStage(1'b1)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .inhibit_i             (inhibit_i),
    .instr_ret_i           (instr_ret_i),
    .instr_ret_compressed_i(instr_ret_compressed_i),
    .instr_ret_spec_i      (instr_ret_spec_i),
    .csr_we_lo_i           (csr_we_lo_i),
    .csr_we_hi_i           (csr_we_hi_i),
    .csr_wdata_i           (csr_wdata_i),
    .minstret_o            (minstret_o),
    .minstret_rd_o         (minstret_rd_o),
    .ret_compressed_cnt_o  (ret_compressed_cnt_o),
    .overflow_o            (overflow_o),
    .overflow_sticky_o     (overflow_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  // Control bits: {rst, inhibit, ret, compressed, spec, we_lo, we_hi}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] wdata;
    logic [63:0] exp_cnt;
    logic [31:0] exp_cmp;
    logic        exp_ovf;
    logic        exp_st;
  } vec_t;

  localparam logic [6:0] RST = 7'b1000000, INH = 7'b0100000, RET = 7'b0010000,
                         CMP = 7'b0001000, SPC = 7'b0000100, WLO = 7'b0000010,
                         WHI = 7'b0000001, NOP = 7'b0000000;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the architectural count as a plain 64-bit number.
  logic [63:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_ovf, m_st, m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd();
    logic [63:0] s;
    s = {63'b0, instr_ret_spec_i & ~inhibit_i};
    if (!SpecRd) return m_cnt;
    if (rst_i) return s;
    return m_cnt + s;
  endfunction

  task automatic model_step();
    if (rst_i) begin
      m_cnt = '0; m_cmp = '0; m_ovf = 1'b0; m_st = 1'b0; m_valid = 1'b1;
    end else if (csr_we_lo_i || csr_we_hi_i) begin
      if (csr_we_lo_i) m_cnt = {m_cnt[63:32], csr_wdata_i};
      if (csr_we_hi_i) m_cnt = {csr_wdata_i, m_cnt[31:0]};
      m_ovf = 1'b0;
      m_st  = 1'b0;
    end else if (instr_ret_i && !inhibit_i) begin
      m_ovf = (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
      if (m_ovf) m_st = 1'b1;
      m_cnt = m_cnt + 64'd1;
      if (instr_ret_compressed_i) m_cmp = m_cmp + 32'd1;
    end else begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic apply(input logic [6:0] ctl, input logic [31:0] wd);
    {rst_i, inhibit_i, instr_ret_i, instr_ret_compressed_i, instr_ret_spec_i,
     csr_we_lo_i, csr_we_hi_i} = ctl;
    csr_wdata_i = wd;
    #1;
    if (m_valid) check("rd", minstret_rd_o, exp_rd());
    @(posedge clk_i);
    model_step();
    #1;
    check("cnt", minstret_o, m_cnt);
    check("cmp", {32'b0, ret_compressed_cnt_o}, {32'b0, m_cmp});
    check("ovf", {63'b0, overflow_o}, {63'b0, m_ovf});
    check("sticky", {63'b0, overflow_sticky_o}, {63'b0, m_st});
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{RST,       32'h0,        64'h0,                   32'd0, 1'b0, 1'b0};
    vecs[1]  = '{WLO|RET,   32'h1234,     64'h1234,                32'd0, 1'b0, 1'b0};
    vecs[2]  = '{RET|CMP,   32'h0,        64'h1235,                32'd1, 1'b0, 1'b0};
    vecs[3]  = '{WLO|WHI,   32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 1'b0};
    vecs[4]  = '{RET,       32'h0,        64'h0,                   32'd1, 1'b1, 1'b1};
    vecs[5]  = '{NOP,       32'h0,        64'h0,                   32'd1, 1'b0, 1'b1};
    vecs[6]  = '{RET,       32'h0,        64'h1,                   32'd1, 1'b0, 1'b1};
    vecs[7]  = '{WHI,       32'h0,        64'h1,                   32'd1, 1'b0, 1'b0};
    vecs[8]  = '{INH|RET|SPC, 32'h0,      64'h1,                   32'd1, 1'b0, 1'b0};
    vecs[9]  = '{WHI,       32'h5,        64'h5_0000_0001,         32'd1, 1'b0, 1'b0};
    vecs[10] = '{RST|RET|WLO, 32'h9,      64'h0,                   32'd0, 1'b0, 1'b0};
    vecs[11] = '{RET,       32'h0,        64'h1,                   32'd0, 1'b0, 1'b0};

    // Table of directed vectors
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].ctl, vecs[i].wdata);
      check("vec_cnt", minstret_o, vecs[i].exp_cnt);
      check("vec_cmp", {32'b0, ret_compressed_cnt_o}, {32'b0, vecs[i].exp_cmp});
      check("vec_ovf", {63'b0, overflow_o}, {63'b0, vecs[i].exp_ovf});
      check("vec_sticky", {63'b0, overflow_sticky_o}, {63'b0, vecs[i].exp_st});
      $display("vec %0d ctl=%b wdata=%h cnt=%h cmp=%0d ovf=%b sticky=%b",
               i, vecs[i].ctl, vecs[i].wdata, minstret_o, ret_compressed_cnt_o,
               overflow_o, overflow_sticky_o);
    end

    // Ten retires after reset, three compressed
    apply(RST, 32'h0);
    for (int i = 0; i < 10; i++)
      apply((i == 1 || i == 4 || i == 7) ? (RET | CMP) : RET, 32'h0);
    check("ten_cnt", minstret_o, 64'd10);
    check("ten_cmp", {32'b0, ret_compressed_cnt_o}, 64'd3);
    $display("seq ten retires: cnt=%0d cmp=%0d", minstret_o, ret_compressed_cnt_o);

    // Inhibited retires leave the count and read value alone
    for (int i = 0; i < 5; i++) apply(INH | RET | SPC, 32'h0);
    check("inh_cnt", minstret_o, 64'd10);
    check("inh_rd", minstret_rd_o, 64'd10);
    $display("seq inhibit: cnt=%0d rd=%0d", minstret_o, minstret_rd_o);

    // Speculative read at count 7
    apply(WLO, 32'd7);
    apply(NOP, 32'h0);
    {rst_i, inhibit_i, instr_ret_i, instr_ret_compressed_i, instr_ret_spec_i,
     csr_we_lo_i, csr_we_hi_i} = SPC;
    #1;
    check("spec_rd", minstret_rd_o, SpecRd ? 64'd8 : 64'd7);
    $display("seq spec read: rd=%0d", minstret_rd_o);

    // Reset at count 50 with a simultaneous write, then resume from 0
    apply(WLO, 32'd48);
    apply(RET, 32'h0);
    apply(RET, 32'h0);
    check("mid_cnt", minstret_o, 64'd50);
    apply(RST | RET | WLO, 32'h77);
    check("rst_cnt", minstret_o, 64'd0);
    check("rst_cmp", {32'b0, ret_compressed_cnt_o}, 64'd0);
    check("rst_ovf", {63'b0, overflow_o}, 64'd0);
    check("rst_sticky", {63'b0, overflow_sticky_o}, 64'd0);
    apply(RET, 32'h0);
    check("resume_cnt", minstret_o, 64'd1);
    $display("seq mid reset: cnt=%0d", minstret_o);

    // Random stimulus with periodic preloads near the wrap point
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      logic [6:0]  c;
      logic [31:0] wd;
      r = $urandom;
      if (i % 150 == 0) begin
        c  = WLO | WHI;
        wd = 32'hFFFFFFFF - {30'b0, r[1:0]};
      end else begin
        c = NOP;
        c[6] = (r[5:0] == 6'd0);
        c[5] = (r[8:6] == 3'd0);
        c[4] = (r[10:9] != 2'd0);
        c[3] = r[11];
        c[2] = r[12];
        c[1] = (r[16:13] == 4'd0);
        c[0] = (r[20:17] == 4'd0);
        wd = r[21] ? 32'hFFFFFFFF : $urandom;
      end
      apply(c, wd);
    end
    $display("random phase done: cnt=%h cmp=%0d", minstret_o, ret_compressed_cnt_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_retire_counter.md
IBEX_RETIRE_COUNTER -- requirements
Module: ibex_retire_counter

Interface
- REQ-001: Parameter CntWidth, default 64: width of retired-instruction counter; legal range 33..64.
- REQ-002: Parameter WritebackStage, default 1'b0: 1 = speculative retire inputs from the writeback stage are honoured; 0 = they are ignored.
- REQ-003: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-004: rst_i  in  1  reset; synchronous, active-high.
- REQ-005: inhibit_i  in  1  1 = counting frozen (mcountinhibit.IR).
- REQ-006: instr_ret_i  in  1  one instruction retired this cycle (writeback-stage retire pulse).
- REQ-007: instr_ret_compressed_i  in  1  retired instruction was compressed; qualified by instr_ret_i.
- REQ-008: instr_ret_spec_i  in  1  instruction held in writeback will count if it retires.
- REQ-009: csr_we_lo_i  in  1  write csr_wdata_i to counter bits [31:0].
- REQ-010: csr_we_hi_i  in  1  write csr_wdata_i[CntWidth-33:0] to counter bits [CntWidth-1:32].
- REQ-011: csr_wdata_i  in  32  CSR write data.
- REQ-012: minstret_o  out  64  architectural count, zero-extended above CntWidth.
- REQ-013: minstret_rd_o  out  64  CSR read value (see REQ-021).
- REQ-014: ret_compressed_cnt_o  out  32  compressed instructions retired, wraps.
- REQ-015: overflow_o  out  1  one-cycle pulse on counter wrap.
- REQ-016: overflow_sticky_o  out  1  set on wrap; held until either CSR write.

Function
- REQ-017: Increment condition: inc = instr_ret_i & ~inhibit_i & ~csr_we_lo_i & ~csr_we_hi_i; when inc, counter += 1 modulo 2^CntWidth, next cycle.
- REQ-018: CSR write has priority over increment in the same cycle; the written instruction's own retire is not counted.
- REQ-019: csr_we_lo_i and csr_we_hi_i in the same cycle: both halves written; each alone leaves the other half unchanged.
- REQ-020: Compressed counter += 1 when inc & instr_ret_compressed_i; unaffected by CSR writes; wraps at 2^32 without flagging.
- REQ-021: minstret_rd_o = counter + (instr_ret_spec_i & ~inhibit_i) when the spec read feature is active (REQ-029, REQ-030); otherwise counter. The sum wraps modulo 2^CntWidth.
- REQ-022: Wrap: when inc and counter = all ones, counter becomes 0 and overflow_o = 1 in the following cycle only; overflow_sticky_o = 1 from that cycle.
- REQ-023: Sticky flag state machine: IDLE -> OVF on wrap; OVF -> IDLE on any CSR write. If a write and a wrap occur in the same cycle, the write wins (no wrap).
- REQ-024: inhibit_i is sampled in the same cycle as instr_ret_i; there is no delay between them.
- REQ-025: Counter update latency is 1 cycle. The counting path is free-running, with no handshake.

Reset
- REQ-026: On rst_i = 1 at a clock edge, all outputs go to 0 in the next cycle: counter, compressed counter, overflow_o, overflow_sticky_o, minstret_o.
- REQ-027: With rst_i asserted, minstret_rd_o = instr_ret_spec_i & ~inhibit_i (when spec read is active); reset overrides a same-cycle CSR write or retire.
- REQ-028: Deasserting reset in the middle of operation: counting resumes from 0 on the first edge with rst_i = 0.

Configuration
- REQ-029: Macro IBEX_RETIRE_SPEC_READ_EN defined: REQ-021 adds the speculative term when WritebackStage = 1.
- REQ-030: Macro not defined: minstret_rd_o = minstret_o always; instr_ret_spec_i is unused.

Verification
- REQ-031: Reset, then 10 cycles of instr_ret_i = 1 with 3 of them compressed -> minstret_o = 10, ret_compressed_cnt_o = 3.
- REQ-032: csr_we_lo_i with wdata 0x1234 and instr_ret_i in the same cycle -> minstret_o = 0x1234 next cycle, with no increment.
- REQ-033: Counter preloaded to 0xFFFFFFFF_FFFFFFFF, then one retire -> minstret_o = 0, overflow_o high for 1 cycle, sticky set; a subsequent csr_we_hi_i clears sticky.
- REQ-034: inhibit_i = 1 with 5 retires -> count unchanged; minstret_rd_o equals minstret_o even with instr_ret_spec_i = 1.
- REQ-035: Macro defined, WritebackStage = 1, counter = 7, instr_ret_spec_i = 1 -> minstret_rd_o = 8; macro undefined -> 7.
- REQ-036: rst_i asserted mid-count at value 50 with a same-cycle write -> all outputs 0 next cycle; counting resumes from 0.
